pwm_bus_sequencer: RTL and testbench

- Bus master that serialises configuration and status accesses from a host-side command stream onto the PWM peripheral's 8-bit shared register bus (write_en, read_en, 6-bit address, bidirectional data).
- Buffers commands in a small FIFO and issues single-byte or atomic MSB/LSB pair accesses, so that 16-bit period, phase and compare fields are never split by another access.
- Inserts bus turnaround cycles and returns read data on a response port.
- Sits between the host interface logic and the peripheral's register file.

---
 rtl/pwm_bus_pkg.sv | 39 +++
 rtl/pwm_bus_cmd_fifo.sv | 52 +++++
 rtl/pwm_bus_sequencer.sv | 154 +++++++++++++++
 tb/tb_pwm_bus_sequencer.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_bus_pkg.sv
// Shared types for the PWM register-bus sequencer: FSM states, access
// direction and the packed command word carried through the FIFO.
package pwm_bus_pkg;

  localparam int unsigned ADDR_W = 6;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CMD_W  = 1 + 1 + ADDR_W + DATA_W;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_TURN,
    ST_WRITE,
    ST_READ
  } state_t;

  typedef enum logic [1:0] {
    DIR_NONE,
    DIR_WR,
    DIR_RD
  } dir_t;

  typedef struct packed {
    logic              write;
    logic              pair;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } cmd_t;

  function automatic dir_t cmd_dir(input cmd_t c);
    return c.write ? DIR_WR : DIR_RD;
  endfunction

  // Byte that goes out on the first write cycle: MSB for a pair, LSB otherwise.
  function automatic logic [BYTE_W-1:0] first_byte(input cmd_t c);
    return c.pair ? c.data[15:8] : c.data[7:0];
  endfunction

endpackage

// File: rtl/pwm_bus_cmd_fifo.sv
// Command FIFO: DEPTH x WIDTH register storage, synchronous reset,
// pushes ignored when full and pops ignored when empty.
module pwm_bus_cmd_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 24
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign o_full  = (o_count == CNT_W'(DEPTH));
  assign o_empty = (o_count == '0);
  assign push_ok = i_push && !o_full;
  assign pop_ok  = i_pop && !o_empty;
  assign o_data  = mem[rd_ptr];

  always_ff @(posedge i_clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= i_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      o_count <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      o_count <= o_count + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

endmodule

// File: rtl/pwm_bus_sequencer.sv
// Serialises buffered host commands onto the PWM peripheral's 8-bit shared
// register bus, keeping MSB/LSB pairs atomic and inserting turnaround cycles.
module pwm_bus_sequencer
  import pwm_bus_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic              i_cmd_write,
  input  logic              i_cmd_pair,
  input  logic [ADDR_W-1:0] i_cmd_address,
  input  logic [DATA_W-1:0] i_cmd_data,
  output logic              o_rsp_valid,
  output logic [DATA_W-1:0] o_rsp_data,
  output logic              o_busy,
  output logic              o_write_en,
  output logic              o_read_en,
  output logic [ADDR_W-1:0] o_address,
  inout  wire  [BYTE_W-1:0] io_data
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned LAT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  logic [CMD_W-1:0] fifo_data;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;

  state_t            state;
  dir_t              last_dir;
  cmd_t              cmd_r;
  logic              second_r;
  logic [LAT_W-1:0]  lat_cnt;
  logic [BYTE_W-1:0] msb_r;
  logic [BYTE_W-1:0] wdata_r;

  cmd_t head;
  cmd_t launch;
  dir_t head_dir;
  logic last_byte;
  logic lat_last;
  logic done;
  logic pop;
  logic turn;
  logic start;

  pwm_bus_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_push  (i_cmd_valid),
    .i_data  ({i_cmd_write, i_cmd_pair, i_cmd_address, i_cmd_data}),
    .i_pop   (pop),
    .o_data  (fifo_data),
    .o_full  (fifo_full),
    .o_empty (fifo_empty),
    .o_count (fifo_count)
  );

  assign o_cmd_ready = !fifo_full;
  assign o_busy      = (fifo_count != '0) || (state != ST_IDLE);
  assign io_data     = o_write_en ? wdata_r : 'z;

  // Next command is popped in the last cycle of the current access so IDLE takes no cycles.
  always_comb begin
    head      = cmd_t'(fifo_data);
    head_dir  = cmd_dir(head);
    last_byte = !cmd_r.pair || second_r;
    lat_last  = (lat_cnt == LAT_W'(READ_LATENCY - 1));
    done      = ((state == ST_WRITE) && last_byte) ||
                ((state == ST_READ) && lat_last && last_byte);
    pop       = !fifo_empty && ((state == ST_IDLE) || done);
    turn      = (last_dir != DIR_NONE) && (last_dir != head_dir);
    start     = (pop && !turn) || (state == ST_TURN);
    launch    = (state == ST_TURN) ? cmd_r : head;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state       <= ST_IDLE;
      last_dir    <= DIR_NONE;
      cmd_r       <= '0;
      second_r    <= 1'b0;
      lat_cnt     <= '0;
      msb_r       <= '0;
      wdata_r     <= '0;
      o_write_en  <= 1'b0;
      o_read_en   <= 1'b0;
      o_address   <= '0;
      o_rsp_valid <= 1'b0;
      o_rsp_data  <= '0;
    end else begin
      o_rsp_valid <= 1'b0;
      if ((state == ST_READ) && lat_last && last_byte) begin
        o_rsp_valid <= 1'b1;
        o_rsp_data  <= cmd_r.pair ? {msb_r, io_data} : {8'h00, io_data};
      end
      if (pop) begin
        cmd_r    <= head;
        last_dir <= head_dir;
      end
      if (start) begin
        second_r   <= 1'b0;
        lat_cnt    <= '0;
        o_address  <= launch.addr;
        o_write_en <= launch.write;
        o_read_en  <= !launch.write;
        wdata_r    <= first_byte(launch);
        state      <= launch.write ? ST_WRITE : ST_READ;
      end else if (pop) begin
        state      <= ST_TURN;
        o_write_en <= 1'b0;
        o_read_en  <= 1'b0;
      end else begin
        case (state)
          ST_WRITE: begin
            if (!last_byte) begin
              second_r  <= 1'b1;
              o_address <= o_address + ADDR_W'(1);
              wdata_r   <= cmd_r.data[7:0];
            end else begin
              state      <= ST_IDLE;
              o_write_en <= 1'b0;
            end
          end
          ST_READ: begin
            if (lat_last) begin
              lat_cnt <= '0;
              if (!last_byte) begin
                msb_r     <= io_data;
                second_r  <= 1'b1;
                o_address <= o_address + ADDR_W'(1);
              end else begin
                state     <= ST_IDLE;
                o_read_en <= 1'b0;
              end
            end else begin
              lat_cnt <= lat_cnt + LAT_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pwm_bus_sequencer.sv
// Scoreboard bench for pwm_bus_sequencer with a pulled-up shared data bus and
// a byte-wide register-file model answering reads.
module tb_pwm_bus_sequencer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned LAT   = 2;

  typedef struct packed {
    logic       wr;
    logic [5:0] addr;
    logic [7:0] data;
  } bus_ev_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_write = 1'b0;
  logic        cmd_pair = 1'b0;
  logic [5:0]  cmd_address = '0;
  logic [15:0] cmd_data = '0;
  logic        cmd_ready;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic        busy;
  logic        write_en;
  logic        read_en;
  logic [5:0]  address;
  wire  [7:0]  io_data;

  logic [7:0] periph [64];
  logic [7:0] ref_rf [64];
  bus_ev_t    exp_bus [$];
  logic [15:0] exp_rsp [$];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit mon_en = 1'b0;
  int wr_run = 0;
  int max_wr_run = 0;
  int last_rd_cyc = 0;
  int rw_gap = -1;
  bit prev_rd = 1'b0;

  pwm_bus_sequencer #(
    .FIFO_DEPTH   (DEPTH),
    .READ_LATENCY (LAT)
  ) dut (
    .i_clk         (clk),
    .i_reset       (rst),
    .i_cmd_valid   (cmd_valid),
    .o_cmd_ready   (cmd_ready),
    .i_cmd_write   (cmd_write),
    .i_cmd_pair    (cmd_pair),
    .i_cmd_address (cmd_address),
    .i_cmd_data    (cmd_data),
    .o_rsp_valid   (rsp_valid),
    .o_rsp_data    (rsp_data),
    .o_busy        (busy),
    .o_write_en    (write_en),
    .o_read_en     (read_en),
    .o_address     (address),
    .io_data       (io_data)
  );

  // Peripheral drives the bus during read strobes; a released bus floats high.
  assign io_data = read_en ? periph[address] : 8'hzz;
  for (genvar g = 0; g < 8; g++) begin : g_pu
    pullup pu (io_data[g]);
  end

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Monitor: pops bus and response expectations as the DUT produces them.
  always @(negedge clk) begin
    bus_ev_t got;
    bus_ev_t e;
    logic [15:0] er;
    if (mon_en) begin
      total++;
      if (write_en && read_en) begin
        bad++;
        $display("FAIL strobe_overlap: write_en=%0b read_en=%0b, required not both", write_en, read_en);
      end
      if (write_en || read_en) begin
        got.wr   = write_en;
        got.addr = address;
        got.data = write_en ? io_data : 8'h00;
        total++;
        if (exp_bus.size() == 0) begin
          bad++;
          $display("FAIL bus_unexpected: got wr=%0b addr=%0d data=%h, required no access", got.wr, got.addr, got.data);
        end else begin
          e = exp_bus.pop_front();
          if (got !== e) begin
            bad++;
            $display("FAIL bus_cycle: got wr=%0b addr=%0d data=%h, required wr=%0b addr=%0d data=%h",
                     got.wr, got.addr, got.data, e.wr, e.addr, e.data);
          end
        end
      end else begin
        total++;
        if (io_data !== 8'hFF) begin
          bad++;
          $display("FAIL bus_release: io_data=%h with no strobe, required released (ff)", io_data);
        end
      end
      if (write_en) begin
        periph[address] = io_data;
        wr_run++;
        if (wr_run > max_wr_run) max_wr_run = wr_run;
        if (prev_rd) rw_gap = cyc - last_rd_cyc;
        prev_rd = 1'b0;
      end else begin
        wr_run = 0;
      end
      if (read_en) begin
        last_rd_cyc = cyc;
        prev_rd = 1'b1;
      end
      if (rsp_valid) begin
        total++;
        if (exp_rsp.size() == 0) begin
          bad++;
          $display("FAIL rsp_unexpected: got %h, required no response", rsp_data);
        end else begin
          er = exp_rsp.pop_front();
          if (rsp_data !== er) begin
            bad++;
            $display("FAIL rsp_data: got %h, required %h", rsp_data, er);
          end
        end
      end
    end
  end

  // Offer one command (caller sits just after an edge); returns just after the accepting edge.
  task automatic send(input bit wr, input bit pair, input logic [5:0] a, input logic [15:0] d,
                      input bit track, output bit waited);
    logic [5:0] a1;
    bus_ev_t ev;
    int n;
    a1 = a + 6'd1;
    waited = 1'b0;
    if (track) begin
      if (wr) begin
        ev.wr = 1'b1;
        if (pair) begin
          ev.addr = a;  ev.data = d[15:8]; exp_bus.push_back(ev); ref_rf[a]  = d[15:8];
          ev.addr = a1; ev.data = d[7:0];  exp_bus.push_back(ev); ref_rf[a1] = d[7:0];
        end else begin
          ev.addr = a;  ev.data = d[7:0];  exp_bus.push_back(ev); ref_rf[a]  = d[7:0];
        end
      end else begin
        ev.wr = 1'b0;
        ev.data = 8'h00;
        for (int i = 0; i < int'(LAT); i++) begin ev.addr = a; exp_bus.push_back(ev); end
        if (pair) begin
          for (int i = 0; i < int'(LAT); i++) begin ev.addr = a1; exp_bus.push_back(ev); end
          exp_rsp.push_back({ref_rf[a], ref_rf[a1]});
        end else begin
          exp_rsp.push_back({8'h00, ref_rf[a]});
        end
      end
    end
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_pair = pair;
    cmd_address = a;
    cmd_data = d;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 100) begin
      waited = 1'b1;
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) begin
      total++; bad++;
      $display("FAIL send_timeout: cmd_ready=%0b after %0d cycles, required 1", cmd_ready, n);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) begin
      total++; bad++;
      $display("FAIL idle_timeout: busy=%0b after %0d cycles, required 0", busy, n);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({write_en, read_en, rsp_valid, busy, cmd_ready} !== 5'b00001) begin
      bad++;
      $display("FAIL reset_ctrl: we=%0b re=%0b rsp=%0b busy=%0b ready=%0b, required 0 0 0 0 1",
               write_en, read_en, rsp_valid, busy, cmd_ready);
    end
    total++;
    if (address !== 6'd0 || rsp_data !== 16'h0000) begin
      bad++;
      $display("FAIL reset_data: addr=%0d rsp_data=%h, required 0 0000", address, rsp_data);
    end
    total++;
    if (io_data !== 8'hFF) begin
      bad++;
      $display("FAIL reset_bus: io_data=%h, required released (ff)", io_data);
    end
    rst = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic test_single_write();
    bit w;
    send(1'b1, 1'b0, 6'h01, 16'h00A5, 1'b1, w);
    total++;
    if (write_en !== 1'b0) begin
      bad++;
      $display("FAIL sw_early: write_en=%0b at accept edge, required 0", write_en);
    end
    @(posedge clk); #1;
    total++;
    if ({write_en, read_en, address, io_data} !== {1'b1, 1'b0, 6'd1, 8'hA5}) begin
      bad++;
      $display("FAIL sw_cycle: we=%0b re=%0b addr=%0d data=%h, required 1 0 1 a5",
               write_en, read_en, address, io_data);
    end
    @(posedge clk); #1;
    total++;
    if ({write_en, rsp_valid, io_data} !== {1'b0, 1'b0, 8'hFF}) begin
      bad++;
      $display("FAIL sw_after: we=%0b rsp=%0b data=%h, required 0 0 ff", write_en, rsp_valid, io_data);
    end
    wait_idle();
  endtask

  task automatic test_pair_write();
    bit w;
    send(1'b1, 1'b1, 6'h02, 16'h1234, 1'b1, w);
    @(posedge clk); #1;
    total++;
    if ({write_en, address, io_data} !== {1'b1, 6'd2, 8'h12}) begin
      bad++;
      $display("FAIL pw_msb: we=%0b addr=%0d data=%h, required 1 2 12", write_en, address, io_data);
    end
    @(posedge clk); #1;
    total++;
    if ({write_en, address, io_data} !== {1'b1, 6'd3, 8'h34}) begin
      bad++;
      $display("FAIL pw_lsb: we=%0b addr=%0d data=%h, required 1 3 34", write_en, address, io_data);
    end
    @(posedge clk); #1;
    total++;
    if ({write_en, io_data} !== {1'b0, 8'hFF}) begin
      bad++;
      $display("FAIL pw_release: we=%0b data=%h, required 0 ff", write_en, io_data);
    end
    wait_idle();
  endtask

  task automatic test_pair_read();
    bit w;
    logic [5:0] ea [4];
    ea[0] = 6'd63; ea[1] = 6'd63; ea[2] = 6'd0; ea[3] = 6'd0;
    send(1'b0, 1'b1, 6'h3F, 16'h0000, 1'b1, w);
    @(posedge clk); #1;
    total++;
    if ({write_en, read_en, busy} !== 3'b001) begin
      bad++;
      $display("FAIL pr_turn: we=%0b re=%0b busy=%0b, required 0 0 1", write_en, read_en, busy);
    end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      total++;
      if ({read_en, write_en, address, rsp_valid} !== {1'b1, 1'b0, ea[i], 1'b0}) begin
        bad++;
        $display("FAIL pr_read%0d: re=%0b we=%0b addr=%0d rsp=%0b, required 1 0 %0d 0",
                 i, read_en, write_en, address, rsp_valid, ea[i]);
      end
    end
    @(posedge clk); #1;
    total++;
    if ({read_en, rsp_valid, rsp_data} !== {1'b0, 1'b1, 16'hABCD}) begin
      bad++;
      $display("FAIL pr_rsp: re=%0b rsp=%0b data=%h, required 0 1 abcd", read_en, rsp_valid, rsp_data);
    end
    @(posedge clk); #1;
    total++;
    if (rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL pr_pulse: rsp_valid=%0b one cycle later, required 0", rsp_valid);
    end
    wait_idle();
  endtask

  task automatic test_back_to_back();
    bit w;
    bit any_wait;
    any_wait = 1'b0;
    max_wr_run = 0;
    rw_gap = -1;
    send(1'b0, 1'b1, 6'h06, 16'h0000, 1'b1, w);
    for (int i = 0; i < 5; i++) begin
      send(1'b1, 1'b0, 6'(8 + i), 16'(16'h0040 + i), 1'b1, w);
      any_wait |= w;
    end
    wait_idle();
    total++;
    if (any_wait !== 1'b1) begin
      bad++;
      $display("FAIL b2b_ready: ready never dropped (%0b), required drop when full", any_wait);
    end
    total++;
    if (max_wr_run != 5) begin
      bad++;
      $display("FAIL b2b_run: longest write run=%0d, required 5", max_wr_run);
    end
    total++;
    if (rw_gap != 2) begin
      bad++;
      $display("FAIL b2b_turn: read-to-write distance=%0d, required 2", rw_gap);
    end
    total++;
    if (exp_bus.size() != 0 || exp_rsp.size() != 0) begin
      bad++;
      $display("FAIL b2b_drain: bus left=%0d rsp left=%0d, required 0 0", exp_bus.size(), exp_rsp.size());
    end
  endtask

  task automatic test_read_write_mix();
    bit w;
    rw_gap = -1;
    send(1'b0, 1'b0, 6'h05, 16'h0000, 1'b1, w);
    send(1'b1, 1'b0, 6'h05, 16'h005A, 1'b1, w);
    wait_idle();
    total++;
    if (rw_gap != 2) begin
      bad++;
      $display("FAIL mix_turn: read-to-write distance=%0d, required 2", rw_gap);
    end
    total++;
    if (exp_bus.size() != 0 || exp_rsp.size() != 0) begin
      bad++;
      $display("FAIL mix_drain: bus left=%0d rsp left=%0d, required 0 0", exp_bus.size(), exp_rsp.size());
    end
  endtask

  task automatic test_reset_midflight();
    bit w;
    int n;
    mon_en = 1'b0;
    send(1'b0, 1'b1, 6'h0A, 16'h0000, 1'b0, w);
    send(1'b1, 1'b0, 6'h20, 16'h0011, 1'b0, w);
    send(1'b1, 1'b1, 6'h21, 16'h2233, 1'b0, w);
    n = 0;
    while (!(read_en === 1'b1 && address === 6'd11) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    total++;
    if (n >= 50) begin
      bad++;
      $display("FAIL rst_reach: second pair byte not seen after %0d cycles, required within 50", n);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total++;
    if ({write_en, read_en, busy, rsp_valid, cmd_ready, io_data} !== {5'b00001, 8'hFF}) begin
      bad++;
      $display("FAIL rst_state: we=%0b re=%0b busy=%0b rsp=%0b ready=%0b data=%h, required 0 0 0 0 1 ff",
               write_en, read_en, busy, rsp_valid, cmd_ready, io_data);
    end
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      total++;
      if ({write_en, read_en, busy, rsp_valid} !== 4'b0000) begin
        bad++;
        $display("FAIL rst_flush%0d: we=%0b re=%0b busy=%0b rsp=%0b, required 0 0 0 0",
                 i, write_en, read_en, busy, rsp_valid);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      periph[i] = 8'(8'h40 + i);
    end
    periph[63] = 8'hAB;
    periph[0]  = 8'hCD;
    for (int i = 0; i < 64; i++) begin
      ref_rf[i] = periph[i];
    end
    test_reset();
    test_single_write();
    test_pair_write();
    test_pair_read();
    test_back_to_back();
    test_read_write_mix();
    test_reset_midflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
